// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word-addressed 16-bit data RAM with valid/ready request/response and wait states
// Optional access counters (rd_cnt/wr_cnt) are built when DMEM_ACCESS_CNT_EN is defined.
module data_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err
`ifdef DMEM_ACCESS_CNT_EN
  ,
  output logic [15:0] rd_cnt,
  output logic [15:0] wr_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  // Counter starts at WAIT_CYCLES so the response shows up WAIT_CYCLES+1 edges after accept.
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

  state_t      state, next_state;
  logic [3:0]  cnt;
  logic        cap_we;
  logic [14:0] cap_addr;
  logic [15:0] cap_wdata;
  logic [15:0] ram [2**ADDR_W];

  logic              accept;
  logic              rsp_fire;
  logic              enter_resp;
  logic              addr_err;
  logic [ADDR_W-1:0] word;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = req_addr[0];

  assign req_ready  = (state == S_IDLE);
  assign rsp_valid  = (state == S_RESP);
  assign accept     = req_valid && req_ready;
  assign rsp_fire   = rsp_valid && rsp_ready;
  assign enter_resp = (state == S_WAIT) && (cnt == 4'd0);
  assign addr_err   = (cap_addr >> ADDR_W) != 15'd0;
  assign word       = cap_addr[ADDR_W-1:0];

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (accept) next_state = S_WAIT;
      S_WAIT:  if (cnt == 4'd0) next_state = S_RESP;
      S_RESP:  if (rsp_fire) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= 4'd0;
      cap_we    <= 1'b0;
      cap_addr  <= 15'd0;
      cap_wdata <= 16'd0;
      rsp_rdata <= 16'd0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        cap_we    <= req_we;
        cap_addr  <= req_addr[15:1];
        cap_wdata <= req_wdata;
        cnt       <= CNT_INIT;
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        rsp_err   <= addr_err;
        rsp_rdata <= (!cap_we && !addr_err) ? ram[word] : 16'd0;
      end
    end
  end

  // Commit happens only on the edge entering RESP, so a reset during WAIT drops the store.
  always_ff @(negedge clk) begin
    if (enter_resp && cap_we && !addr_err) begin
      ram[word] <= cap_wdata;
    end
  end

`ifdef DMEM_ACCESS_CNT_EN
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt <= 16'd0;
      wr_cnt <= 16'd0;
    end else if (rsp_fire && !rsp_err) begin
      if (cap_we) begin
        wr_cnt <= wr_cnt + 16'd1;
      end else begin
        rd_cnt <= rd_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized scoreboard bench for data_mem_responder
module tb_data_mem_responder;
  localparam int ADDR_W = 8;
  localparam int W      = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [15:0] req_addr = 16'd0;
  logic [15:0] req_wdata = 16'd0;
  logic        rsp_ready = 1'b0;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
`ifdef DMEM_ACCESS_CNT_EN
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;
`endif

  data_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
`ifdef DMEM_ACCESS_CNT_EN
    , .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int edge_cnt = 0;
  always @(negedge clk) edge_cnt++;

  logic [16:0] exp_q[$];
  int          acc_q[$];
  logic [15:0] model [0:255];
  int          rd_m = 0;
  int          wr_m = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: byte address >= 2*depth is an error; word = addr/2.
  function automatic logic [16:0] predict(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    int a;
    logic err;
    a = int'(addr);
    err = (a >= (2 << ADDR_W));
    if (we) begin
      if (!err) begin
        model[a / 2] = wdata;
        wr_m++;
      end
      return {err, 16'h0000};
    end
    if (err) return {1'b1, 16'h0000};
    rd_m++;
    return {1'b0, model[a / 2]};
  endfunction

  logic prev_valid = 1'b0;
  always @(posedge clk) begin : monitor
    logic [16:0] e;
    if (rst_n && rsp_valid && !prev_valid) begin
      if (acc_q.size() == 0) check("spurious_rsp_valid", 1, 0);
      else check("rsp_latency_edges", edge_cnt - acc_q.pop_front(), W + 1);
    end
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e[15:0]);
        check("rsp_err", rsp_err, e[16]);
      end
    end
    prev_valid <= rsp_valid;
  end

  task automatic txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata, input int hold);
    int t;
    logic [16:0] e;
    @(negedge clk); #1;
    t = 0;
    while (!req_ready && t < 50) begin @(negedge clk); #1; t++; end
    if (!req_ready) check("req_ready_timeout", 0, 1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    acc_q.push_back(edge_cnt + 1);
    e = predict(we, addr, wdata);
    exp_q.push_back(e);
    @(negedge clk); #1;
    // Keep req_valid high with junk: must be ignored until back in IDLE.
    req_we = 1'($urandom); req_addr = 16'($urandom); req_wdata = 16'($urandom);
    t = 0;
    while (!rsp_valid && t < 50) begin @(negedge clk); #1; t++; end
    if (!rsp_valid) check("rsp_valid_timeout", 0, 1);
    check("req_ready_busy", req_ready, 0);
    for (int i = 0; i < hold; i++) begin
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_rdata", rsp_rdata, e[15:0]);
      check("hold_req_ready", req_ready, 0);
      @(negedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("req_ready_after_hs", req_ready, 1);
    check("rsp_valid_after_hs", rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    repeat (2) @(negedge clk);
    #1;
    check("reset_req_ready", req_ready, 1);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_rdata", rsp_rdata, 0);
    check("reset_rsp_err", rsp_err, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) txn(1'b1, 16'(2 * i), (i == 1) ? 16'hBEEF : 16'($urandom), 0);

    // Abort a store to word 3 while it is still waiting.
    @(negedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0006; req_wdata = ~model[3];
    @(negedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_req_ready", req_ready, 1);
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_rsp_rdata", rsp_rdata, 0);
    rd_m = 0; wr_m = 0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    txn(1'b0, 16'h0006, 16'h0, 0);

    txn(1'b1, 16'h0004, 16'h0016, 0);
    txn(1'b0, 16'h0004, 16'h0, 0);
    txn(1'b0, 16'h0002, 16'h0, 5);
    txn(1'b1, 16'h0200, 16'h1234, 1);
    txn(1'b0, 16'h0000, 16'h0, 0);
    txn(1'b0, 16'h0005, 16'h0, 0);
    txn(1'b0, 16'hFFFF, 16'h0, 2);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) a = 16'($urandom_range(512, 65535));
      else a = 16'($urandom_range(0, 31));
      txn(1'($urandom), a, 16'($urandom), $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
`ifdef DMEM_ACCESS_CNT_EN
    check("rd_cnt", rd_cnt, 32'(rd_m));
    check("wr_cnt", wr_cnt, 32'(wr_m));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
